axi4_lite_master: RTL and testbench

- AXI4-Lite initiator that turns single-beat commands from a local requester into AXI4-Lite read or write transactions.
- Connects to the team's AXI4-Lite RAM and register slaves.
- Handles one transaction at a time. Read data and response code are returned to the requester over a valid/ready response channel.

---
 rtl/axi4_lite_pkg.sv | 44 ++++
 rtl/axi4_lite_if.sv | 52 +++++
 rtl/axi4_lite_master.sv | 160 ++++++++++++++++
 tb/tb_axi4_lite_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Brief    : Shared AXI4-Lite types: response codes, master FSM states and
//            command/response records sized for the widest supported bus.
// Revision : 1.0
// ============================================================================
package axi4_lite_pkg;

    localparam int AXIL_MAX_DATA_WIDTH = 64;
    localparam int AXIL_MAX_ADDR_WIDTH = 32;
    localparam int AXIL_MAX_STRB_WIDTH = AXIL_MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        WR_AW_W = 6'b000010,
        WR_B    = 6'b000100,
        RD_AR   = 6'b001000,
        RD_R    = 6'b010000,
        RESP    = 6'b100000
    } master_state_t;

    typedef struct packed {
        logic                           write;
        logic [AXIL_MAX_ADDR_WIDTH-1:0] addr;
        logic [AXIL_MAX_DATA_WIDTH-1:0] wdata;
        logic [AXIL_MAX_STRB_WIDTH-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic                           write;
        logic [AXIL_MAX_DATA_WIDTH-1:0] rdata;
        resp_t                          resp;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Brief    : AXI4-Lite five-channel bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi4_lite_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;

    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input  aw_addr, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Brief    : Single-outstanding AXI4-Lite initiator; local command in,
//            AXI read/write out, registered response back to the requester.
// Revision : 1.0
// ============================================================================
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 10,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,

    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    input  wire logic                  cmd_write,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [DATA_WIDTH-1:0] cmd_wdata,
    input  wire logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                       rsp_valid,
    input  wire logic                  rsp_ready,
    output logic                       rsp_write,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [1:0]                 rsp_resp,

    axi4_lite_if.master                axi
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
        $error("axi4_lite_master: DATA_WIDTH must be 32 or 64");
    end

    master_state_t state;
    master_state_t state_next;
    logic          aw_done;
    logic          w_done;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic cmd_hs;
    logic rsp_hs;
    logic aw_w_complete;

    assign aw_hs  = axi.aw_valid & axi.aw_ready;
    assign w_hs   = axi.w_valid  & axi.w_ready;
    assign b_hs   = axi.b_valid  & axi.b_ready;
    assign ar_hs  = axi.ar_valid & axi.ar_ready;
    assign r_hs   = axi.r_valid  & axi.r_ready;
    assign cmd_hs = cmd_valid & cmd_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    // AW and W may finish in either order or together; count this cycle's handshakes too.
    assign aw_w_complete = (aw_done | aw_hs) & (w_done | w_hs);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_hs)        state_next = cmd_write ? WR_AW_W : RD_AR;
            WR_AW_W: if (aw_w_complete) state_next = WR_B;
            WR_B:    if (b_hs)          state_next = RESP;
            RD_AR:   if (ar_hs)         state_next = RD_R;
            RD_R:    if (r_hs)          state_next = RESP;
            RESP:    if (rsp_hs)        state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            axi.aw_addr  <= '0;
            axi.aw_valid <= 1'b0;
            axi.w_data   <= '0;
            axi.w_strb   <= '0;
            axi.w_valid  <= 1'b0;
            axi.b_ready  <= 1'b0;
            axi.ar_addr  <= '0;
            axi.ar_valid <= 1'b0;
            axi.r_ready  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);

            unique case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (cmd_write) begin
                            axi.aw_addr  <= cmd_addr;
                            axi.w_data   <= cmd_wdata;
                            axi.w_strb   <= cmd_wstrb;
                            axi.aw_valid <= 1'b1;
                            axi.w_valid  <= 1'b1;
                        end else begin
                            axi.ar_addr  <= cmd_addr;
                            axi.ar_valid <= 1'b1;
                        end
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) begin
                        axi.aw_valid <= 1'b0;
                        aw_done      <= 1'b1;
                    end
                    if (w_hs) begin
                        axi.w_valid <= 1'b0;
                        w_done      <= 1'b1;
                    end
                    if (aw_w_complete) axi.b_ready <= 1'b1;
                end
                WR_B: begin
                    if (b_hs) begin
                        axi.b_ready <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= axi.b_resp;
                    end
                end
                RD_AR: begin
                    if (ar_hs) begin
                        axi.ar_valid <= 1'b0;
                        axi.r_ready  <= 1'b1;
                    end
                end
                RD_R: begin
                    if (r_hs) begin
                        axi.r_ready <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b0;
                        rsp_rdata   <= axi.r_data;
                        rsp_resp    <= axi.r_resp;
                    end
                end
                RESP: begin
                    if (rsp_hs) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master
// Brief    : Directed bench with a configurable-latency slave and a response
//            scoreboard for axi4_lite_master.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axi4_lite_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi4_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Slave knobs and expected AXI payloads
    int            aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]    b_resp_k = 2'b00, r_resp_k = 2'b00;
    logic [DW-1:0] r_data_k = '0;
    bit            b_hold = 1'b0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_wstrb = '0;

    rsp_t exp_q[$];

    int cyc = 0;
    int acc_n = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
    int acc_cyc = 0, aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0;

    // Slave: each ready rises after its programmed number of wait cycles
    initial begin
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = 2'b00;
        axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_data = '0;
        forever begin
            @(negedge clk);
            if (axi.aw_valid) begin
                if (aw_cnt < aw_lat) begin aw_cnt++; axi.aw_ready = 1'b0; end
                else axi.aw_ready = 1'b1;
            end else begin aw_cnt = 0; axi.aw_ready = 1'b0; end
            if (axi.w_valid) begin
                if (w_cnt < w_lat) begin w_cnt++; axi.w_ready = 1'b0; end
                else axi.w_ready = 1'b1;
            end else begin w_cnt = 0; axi.w_ready = 1'b0; end
            if (axi.ar_valid) begin
                if (ar_cnt < ar_lat) begin ar_cnt++; axi.ar_ready = 1'b0; end
                else axi.ar_ready = 1'b1;
            end else begin ar_cnt = 0; axi.ar_ready = 1'b0; end
            if (axi.b_ready && !b_hold) begin axi.b_valid = 1'b1; axi.b_resp = b_resp_k; end
            else begin axi.b_valid = 1'b0; axi.b_resp = 2'b00; end
            if (axi.r_ready) begin axi.r_valid = 1'b1; axi.r_data = r_data_k; axi.r_resp = r_resp_k; end
            else begin axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; end
        end
    end

    // Monitor: protocol stability, payload checks and the response scoreboard
    initial begin
        logic p_aw_pend = 1'b0, p_aw_hs = 1'b0, p_w_pend = 1'b0, p_w_hs = 1'b0;
        logic p_ar_pend = 1'b0, p_ar_hs = 1'b0, p_rsp_pend = 1'b0;
        logic [AW-1:0] p_aw_addr = '0, p_ar_addr = '0;
        logic [DW-1:0] p_w_data = '0, p_rsp_rdata = '0;
        logic [SW-1:0] p_w_strb = '0;
        logic          p_rsp_write = 1'b0;
        logic [1:0]    p_rsp_resp = 2'b00;
        rsp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                p_aw_pend = 0; p_aw_hs = 0; p_w_pend = 0; p_w_hs = 0;
                p_ar_pend = 0; p_ar_hs = 0; p_rsp_pend = 0;
            end else begin
                if (p_aw_pend) check("aw_hold", 64'({axi.aw_valid, axi.aw_addr}), 64'({1'b1, p_aw_addr}));
                if (p_w_pend)  check("w_hold", 64'({axi.w_valid, axi.w_strb, axi.w_data}), 64'({1'b1, p_w_strb, p_w_data}));
                if (p_ar_pend) check("ar_hold", 64'({axi.ar_valid, axi.ar_addr}), 64'({1'b1, p_ar_addr}));
                if (p_aw_hs)   check("aw_drop", 64'(axi.aw_valid), 64'(0));
                if (p_w_hs)    check("w_drop", 64'(axi.w_valid), 64'(0));
                if (p_ar_hs)   check("ar_drop", 64'(axi.ar_valid), 64'(0));
                if (p_rsp_pend) check("rsp_hold", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                                      64'({1'b1, p_rsp_write, p_rsp_resp, p_rsp_rdata}));

                if (cmd_valid && cmd_ready) begin acc_n++; acc_cyc = cyc; end
                if (axi.aw_valid && axi.aw_ready) begin
                    aw_n++; aw_cyc = cyc;
                    check("aw_addr", 64'(axi.aw_addr), 64'(exp_addr));
                end
                if (axi.w_valid && axi.w_ready) begin
                    w_n++; w_cyc = cyc;
                    check("w_payload", 64'({axi.w_strb, axi.w_data}), 64'({exp_wstrb, exp_wdata}));
                end
                if (axi.ar_valid && axi.ar_ready) begin
                    ar_n++; ar_cyc = cyc;
                    check("ar_addr", 64'(axi.ar_addr), 64'(exp_addr));
                end
                if (axi.b_valid && axi.b_ready) begin b_n++; b_cyc = cyc; end
                if (axi.r_valid && axi.r_ready) r_n++;
                if (rsp_valid && rsp_ready) begin
                    rsp_n++;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_write", 64'(rsp_write), 64'(e.write));
                        check("rsp_rdata", 64'(rsp_rdata), e.rdata);
                        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    end
                end

                p_aw_pend = axi.aw_valid & ~axi.aw_ready; p_aw_hs = axi.aw_valid & axi.aw_ready;
                p_w_pend  = axi.w_valid  & ~axi.w_ready;  p_w_hs  = axi.w_valid  & axi.w_ready;
                p_ar_pend = axi.ar_valid & ~axi.ar_ready; p_ar_hs = axi.ar_valid & axi.ar_ready;
                p_rsp_pend = rsp_valid & ~rsp_ready;
                p_aw_addr = axi.aw_addr; p_ar_addr = axi.ar_addr;
                p_w_data = axi.w_data; p_w_strb = axi.w_strb;
                p_rsp_write = rsp_write; p_rsp_resp = rsp_resp; p_rsp_rdata = rsp_rdata;
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [DW-1:0] exp_rd, input logic [1:0] exp_rs);
        rsp_t e;
        int   start;
        int   n;
        e.write = wr;
        e.rdata = AXIL_MAX_DATA_WIDTH'(exp_rd);
        e.resp  = resp_t'(exp_rs);
        exp_q.push_back(e);
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        @(negedge clk);
        start = acc_n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (acc_n == start && n < 50) begin @(negedge clk); n++; end
        cmd_valid = 1'b0;
        check("cmd_accepted", 64'(acc_n - start), 64'(1));
    endtask

    task automatic wait_rsp(input int start);
        int n = 0;
        while (rsp_n == start && n < 100) begin @(negedge clk); n++; end
        check("rsp_arrived", 64'(rsp_n - start), 64'(1));
    endtask

    task automatic transact(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [DW-1:0] exp_rd, input logic [1:0] exp_rs);
        int s_aw = aw_n, s_w = w_n, s_b = b_n, s_ar = ar_n, s_r = r_n, s_rsp = rsp_n;
        issue(wr, a, d, s, exp_rd, exp_rs);
        wait_rsp(s_rsp);
        if (wr) check("wr_hs_counts", 64'({8'(aw_n - s_aw), 8'(w_n - s_w), 8'(b_n - s_b), 8'(ar_n - s_ar)}),
                      64'({8'd1, 8'd1, 8'd1, 8'd0}));
        else    check("rd_hs_counts", 64'({8'(ar_n - s_ar), 8'(r_n - s_r), 8'(aw_n - s_aw), 8'(w_n - s_w)}),
                      64'({8'd1, 8'd1, 8'd0, 8'd0}));
    endtask

    function automatic logic [7:0] ctrl_outs();
        return {cmd_ready, rsp_valid, axi.aw_valid, axi.w_valid, axi.b_ready,
                axi.ar_valid, axi.r_ready, 1'b0};
    endfunction

    initial begin
        int n;
        int s_rsp;

        // Reset state
        #12;
        check("reset_ctrl", 64'(ctrl_outs()), 64'(0));
        check("reset_payload", 64'({axi.aw_addr, axi.ar_addr, axi.w_strb}), 64'(0));
        check("reset_wdata", 64'(axi.w_data), 64'(0));
        check("reset_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        // Zero-wait write
        transact(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
        check("wr_aw_w_same_cycle", 64'(w_cyc - aw_cyc), 64'(0));
        check("wr_latency", 64'(b_cyc - acc_cyc), 64'(2));

        // Skewed write: W ready three cycles after AW
        w_lat = 3;
        transact(1'b1, 10'h024, 32'h12345678, 4'h3, 32'h0, 2'b00);
        check("skew_w_after_aw", 64'(w_cyc - aw_cyc), 64'(3));
        w_lat = 0;

        // Read back with AR stalled four cycles
        ar_lat = 4; r_data_k = 32'hDEADBEEF; r_resp_k = 2'b00;
        transact(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
        check("ar_stall_cycles", 64'(ar_cyc - acc_cyc), 64'(5));
        ar_lat = 0;

        // Error passthrough, then normal traffic
        r_data_k = 32'hCAFEF00D; r_resp_k = 2'b10;
        transact(1'b0, 10'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 2'b10);
        b_resp_k = 2'b01;
        transact(1'b1, 10'h004, 32'h0000A5A5, 4'h1, 32'h0, 2'b01);
        r_data_k = 32'h00000001; r_resp_k = 2'b11;
        transact(1'b0, 10'h008, 32'h0, 4'h0, 32'h00000001, 2'b11);
        b_resp_k = 2'b00; r_resp_k = 2'b00;

        // Response backpressure
        rsp_ready = 1'b0;
        r_data_k = 32'h55AA55AA;
        s_rsp = rsp_n;
        issue(1'b0, 10'h020, 32'h0, 4'h0, 32'h55AA55AA, 2'b00);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_quiet", 64'(ctrl_outs()), 64'(8'b0100_0000));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_back_to_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        check("bp_one_rsp", 64'(rsp_n - s_rsp), 64'(1));

        // Reset while waiting in WR_B
        b_hold = 1'b1;
        s_rsp = rsp_n;
        issue(1'b1, 10'h030, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b00);
        n = 0;
        while (!axi.b_ready && n < 50) begin @(negedge clk); n++; end
        check("mid_wr_b_ready", 64'(axi.b_ready), 64'(1));
        #2 rst_n = 1'b0;
        #1 check("mid_reset_ctrl", 64'(ctrl_outs()), 64'(0));
        exp_q.delete();
        b_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_no_rsp", 64'(rsp_n - s_rsp), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        r_data_k = 32'h0BADF00D;
        transact(1'b0, 10'h010, 32'h0, 4'h0, 32'h0BADF00D, 2'b00);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
